read_ptr_ctrl: RTL and testbench

Read-side pointer and status controller for the dual-clock FIFO, in the read clock domain. Advances the binary read address on accepted reads and publishes a registered Gray-coded read pointer for synchronisation into the write domain. Takes the write pointer already synchronised into the read domain and produces a registered `empty` flag, a fill-level estimate, an `almost_empty` flag and a sticky underflow flag.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/read_ptr_ctrl_if.sv | 28 ++
 rtl/gray2bin.sv | 17 +
 rtl/read_ptr_ctrl.sv | 86 ++++++++
 tb/tb_read_ptr_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer types and Gray-code helpers for both sides of the dual-clock FIFO.
package fifo_pkg;

  // Widest pointer any FIFO instance may use. Each side declares its own
  // ptr_width+1 bit pointers and truncates ptr_t results to that width.
  localparam int unsigned MaxPtrBits = 17;

  typedef logic [MaxPtrBits-1:0] ptr_t;

  // Zero-extended inputs give correct low bits after truncation to the real width.
  function automatic ptr_t bin2gray(ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(ptr_t g);
    ptr_t b;
    b = '0;
    for (int i = 0; i < int'(MaxPtrBits); i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/read_ptr_ctrl_if.sv
// Read-side FIFO bus: request/clear and sync'd write pointer in, pointers and status out.
interface read_ptr_ctrl_if #(
  parameter int unsigned ptr_width = 8
) ();

  logic               r_en;
  logic               uf_clr;
  logic [ptr_width:0] wptr_sync;
  logic [ptr_width:0] raddr;
  logic [ptr_width:0] rptr;
  logic               empty;
  logic               almost_empty;
  logic [ptr_width:0] rd_level;
  logic               underflow;

  // Reader / stimulus side.
  modport master (
    output r_en, uf_clr, wptr_sync,
    input  raddr, rptr, empty, almost_empty, rd_level, underflow
  );

  // Pointer controller side.
  modport slave (
    input  r_en, uf_clr, wptr_sync,
    output raddr, rptr, empty, almost_empty, rd_level, underflow
  );

endinterface

// File: rtl/gray2bin.sv
// Purely combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin #(
  parameter int unsigned width = 4
) (
  input  logic [width-1:0] gray,
  output logic [width-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < int'(width); i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/read_ptr_ctrl.sv
// Read-domain pointer and status controller for the dual-clock FIFO.
module read_ptr_ctrl #(
  parameter int unsigned ptr_width = 8,
  parameter int unsigned ae_thresh = 2
) (
  input  logic           rclk,
  input  logic           r_rst_n,
  read_ptr_ctrl_if.slave bus
);

  typedef logic [ptr_width:0] pw_t;

  localparam pw_t AeLevel = pw_t'(ae_thresh);

  pw_t  raddr_q, raddr_d;
  pw_t  rptr_q, rptr_d;
  pw_t  level_q, level_d;
  pw_t  wbin;
  logic empty_q, empty_d;
  logic ae_q, ae_d;
  logic uf_q, uf_d;
  logic accept;

  gray2bin #(
    .width(ptr_width + 1)
  ) u_wbin (
    .gray(bus.wptr_sync),
    .bin (wbin)
  );

  // Next-state: advance on accepted reads, derive status from the new pointer.
  always_comb begin
    accept  = bus.r_en & ~empty_q;
    raddr_d = raddr_q + pw_t'(accept);
    rptr_d  = pw_t'(fifo_pkg::bin2gray(fifo_pkg::ptr_t'(raddr_d)));
    empty_d = (rptr_d == bus.wptr_sync);
    // Modular subtraction stays correct across the MSB wrap.
    level_d = wbin - raddr_d;
    ae_d    = (level_d <= AeLevel);
    // Set has priority over clear.
    uf_d    = uf_q;
    if (bus.uf_clr) uf_d = 1'b0;
    if (bus.r_en && empty_q) uf_d = 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge rclk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      raddr_q <= '0;
      rptr_q  <= '0;
    end else begin
      raddr_q <= raddr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Status registers; empty resets high so the first cycle blocks reads.
  always_ff @(posedge rclk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      empty_q <= 1'b1;
      level_q <= '0;
      ae_q    <= 1'b1;
    end else begin
      empty_q <= empty_d;
      level_q <= level_d;
      ae_q    <= ae_d;
    end
  end

  // Sticky underflow flag.
  always_ff @(posedge rclk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      uf_q <= 1'b0;
    end else begin
      uf_q <= uf_d;
    end
  end

  assign bus.raddr        = raddr_q;
  assign bus.rptr         = rptr_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = ae_q;
  assign bus.rd_level     = level_q;
  assign bus.underflow    = uf_q;

endmodule

// File: tb/tb_read_ptr_ctrl.sv
// Directed bench for read_ptr_ctrl with ptr_width=3, ae_thresh=2.
module tb_read_ptr_ctrl;

  logic rclk;
  logic r_rst_n;
  int   checks;
  int   errors;

  read_ptr_ctrl_if #(.ptr_width(3)) bus ();

  read_ptr_ctrl #(
    .ptr_width(3),
    .ae_thresh(2)
  ) dut (
    .rclk   (rclk),
    .r_rst_n(r_rst_n),
    .bus    (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic test_reset();
    bus.r_en      = 1'b0;
    bus.uf_clr    = 1'b0;
    bus.wptr_sync = 4'b0110;
    step();
    #3;
    r_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.raddr, bus.rptr, bus.empty, bus.rd_level, bus.almost_empty, bus.underflow}
        !== {4'd0, 4'b0000, 1'b1, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset: raddr=%0d rptr=%b empty=%b lvl=%0d ae=%b uf=%b, need 0 0000 1 0 1 0",
               bus.raddr, bus.rptr, bus.empty, bus.rd_level, bus.almost_empty, bus.underflow);
    end
    bus.wptr_sync = 4'b0000;
    step();
    r_rst_n = 1'b1;
    step();
    checks++;
    if ({bus.raddr, bus.empty, bus.rd_level} !== {4'd0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset_release: raddr=%0d empty=%b lvl=%0d, need 0 1 0",
               bus.raddr, bus.empty, bus.rd_level);
    end
  endtask

  task automatic test_write_arrival();
    bus.r_en      = 1'b0;
    bus.wptr_sync = 4'b0010;
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL arrival_pre: empty=%b, need 1", bus.empty);
    end
    step();
    checks++;
    if ({bus.empty, bus.rd_level, bus.almost_empty} !== {1'b0, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL arrival: empty=%b lvl=%0d ae=%b, need 0 3 0",
               bus.empty, bus.rd_level, bus.almost_empty);
    end
  endtask

  task automatic test_drain();
    logic [3:0] exp_addr [4];
    logic [3:0] exp_ptr  [4];
    logic [3:0] exp_lvl  [4];
    logic       exp_emp  [4];
    logic       exp_uf   [4];
    exp_addr = '{4'd1, 4'd2, 4'd3, 4'd3};
    exp_ptr  = '{4'b0001, 4'b0011, 4'b0010, 4'b0010};
    exp_lvl  = '{4'd2, 4'd1, 4'd0, 4'd0};
    exp_emp  = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_uf   = '{1'b0, 1'b0, 1'b0, 1'b1};
    bus.r_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({bus.raddr, bus.rptr, bus.rd_level, bus.empty, bus.almost_empty, bus.underflow}
          !== {exp_addr[i], exp_ptr[i], exp_lvl[i], exp_emp[i], 1'b1, exp_uf[i]}) begin
        errors++;
        $display("FAIL drain%0d: raddr=%0d rptr=%b lvl=%0d empty=%b ae=%b uf=%b, need %0d %b %0d %b 1 %b",
                 i, bus.raddr, bus.rptr, bus.rd_level, bus.empty, bus.almost_empty,
                 bus.underflow, exp_addr[i], exp_ptr[i], exp_lvl[i], exp_emp[i], exp_uf[i]);
      end
    end
    bus.r_en = 1'b0;
  endtask

  task automatic test_uf_clear();
    bus.r_en   = 1'b0;
    bus.uf_clr = 1'b1;
    step();
    checks++;
    if (bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_clear: uf=%b, need 0", bus.underflow);
    end
    bus.uf_clr = 1'b0;
    bus.r_en   = 1'b1;
    step();
    checks++;
    if (bus.underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_reset: uf=%b, need 1", bus.underflow);
    end
    bus.uf_clr = 1'b1;
    step();
    checks++;
    if ({bus.underflow, bus.raddr} !== {1'b1, 4'd3}) begin
      errors++;
      $display("FAIL uf_set_wins: uf=%b raddr=%0d, need 1 3", bus.underflow, bus.raddr);
    end
    bus.uf_clr = 1'b1;
    bus.r_en   = 1'b0;
    step();
    bus.uf_clr = 1'b0;
  endtask

  task automatic test_wrap();
    bus.wptr_sync = 4'b0001;
    step();
    checks++;
    if ({bus.empty, bus.rd_level} !== {1'b0, 4'd14}) begin
      errors++;
      $display("FAIL wrap_load: empty=%b lvl=%0d, need 0 14", bus.empty, bus.rd_level);
    end
    bus.r_en = 1'b1;
    repeat (11) step();
    checks++;
    if ({bus.raddr, bus.rd_level, bus.almost_empty} !== {4'd14, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL wrap_pre: raddr=%0d lvl=%0d ae=%b, need 14 3 0",
               bus.raddr, bus.rd_level, bus.almost_empty);
    end
    step();
    checks++;
    if ({bus.raddr, bus.rptr, bus.rd_level, bus.almost_empty} !== {4'd15, 4'b1000, 4'd2, 1'b1}) begin
      errors++;
      $display("FAIL wrap_15: raddr=%0d rptr=%b lvl=%0d ae=%b, need 15 1000 2 1",
               bus.raddr, bus.rptr, bus.rd_level, bus.almost_empty);
    end
    step();
    checks++;
    if ({bus.raddr, bus.rptr, bus.rd_level, bus.empty} !== {4'd0, 4'b0000, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_0: raddr=%0d rptr=%b lvl=%0d empty=%b, need 0 0000 1 0",
               bus.raddr, bus.rptr, bus.rd_level, bus.empty);
    end
    bus.r_en = 1'b0;
    bus.r_en = 1'b1;
    step();
    checks++;
    if ({bus.raddr, bus.rptr, bus.rd_level, bus.empty, bus.underflow}
        !== {4'd1, 4'b0001, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_1: raddr=%0d rptr=%b lvl=%0d empty=%b uf=%b, need 1 0001 0 1 0",
               bus.raddr, bus.rptr, bus.rd_level, bus.empty, bus.underflow);
    end
    bus.r_en = 1'b0;
  endtask

  task automatic test_concurrent();
    bus.wptr_sync = 4'b0111;
    step();
    checks++;
    if ({bus.rd_level, bus.empty, bus.almost_empty} !== {4'd4, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL conc_load: lvl=%0d empty=%b ae=%b, need 4 0 0",
               bus.rd_level, bus.empty, bus.almost_empty);
    end
    bus.wptr_sync = 4'b0101;
    bus.r_en      = 1'b1;
    step();
    checks++;
    if ({bus.raddr, bus.rptr, bus.rd_level, bus.empty} !== {4'd2, 4'b0011, 4'd4, 1'b0}) begin
      errors++;
      $display("FAIL concurrent: raddr=%0d rptr=%b lvl=%0d empty=%b, need 2 0011 4 0",
               bus.raddr, bus.rptr, bus.rd_level, bus.empty);
    end
    bus.r_en = 1'b0;
    step();
    checks++;
    if ({bus.raddr, bus.rd_level} !== {4'd2, 4'd4}) begin
      errors++;
      $display("FAIL conc_hold: raddr=%0d lvl=%0d, need 2 4", bus.raddr, bus.rd_level);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    bus.r_en      = 1'b0;
    bus.uf_clr    = 1'b0;
    bus.wptr_sync = 4'b0000;
    r_rst_n       = 1'b0;
    #12;
    r_rst_n = 1'b1;
    test_reset();
    test_write_arrival();
    test_drain();
    test_uf_clear();
    test_wrap();
    test_concurrent();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
